mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, RAM word width (multiple of 8); ADDR_WIDTH, 6, RAM word-address width; BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived).
REQ-002 Ports SHALL be:
- clock  in  1  single clock; also drives the RAM write_clock.
- reset_n  in  1  asynchronous reset, active-low.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  store data.
- req_be  in  BE_WIDTH  store byte enables.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  load data; 0 for stores.
- ram_data  out  DATA_WIDTH  to RAM data.
- ram_read_addr  out  ADDR_WIDTH  to RAM read_addr.
- ram_write_addr  out  ADDR_WIDTH  to RAM write_addr.
- ram_we  out  1  to RAM we.
- ram_q  in  DATA_WIDTH  from RAM q (registered, 1-cycle read latency, old data on same-address collision).

Function
REQ-003 The FSM SHALL have four states: IDLE, RD, WR, RSP.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where req_valid && req_ready, latching req_we, req_addr, req_wdata and req_be.
REQ-005 The requester SHALL hold all req_* stable while req_valid=1 and req_ready=0; the controller processes exactly one request at a time.
REQ-006 On accepting a load, the FSM SHALL go IDLE->RD->RSP->IDLE.
- RD drives ram_read_addr = latched address.
- RSP asserts resp_valid=1 with resp_rdata = ram_q.
- Acceptance edge to resp_valid is 2 cycles.
REQ-007 A store with all byte enables set SHALL go IDLE->WR->IDLE.
- WR asserts ram_we=1, ram_write_addr = addr, ram_data = wdata, resp_valid=1, resp_rdata=0.
REQ-008 A store with req_be=0 SHALL go IDLE->WR->IDLE with ram_we=0 and resp_valid=1 (no-op ack).
REQ-009 ram_we SHALL be asserted only in WR and decoded combinationally from state, never from req_* directly.
REQ-010 Outside WR, ram_data and ram_write_addr SHALL hold their last values; outside RD, ram_read_addr SHALL hold its last value.
REQ-011 A load issued after a store to the same address SHALL return the new data (serialisation guarantees the RAM write edge precedes the read sample edge).
REQ-012 Minimum spacing SHALL be: loads 3 cycles per request; full stores 2 cycles per request.

Reset
REQ-013 While reset_n=0, the FSM SHALL be in IDLE and all registered outputs and latched fields SHALL be 0. ram_we=0, resp_valid=0, req_ready=0 during reset, and req_ready=1 from the first cycle after release.
REQ-014 Reset asserted mid-operation SHALL drop the in-flight request immediately, with no RAM write and no response; ram_we falls asynchronously with state.

Configuration
REQ-015 Macro MEM_CTRL_BYTE_STORE_EN SHALL select partial-store handling.
REQ-016 With MEM_CTRL_BYTE_STORE_EN defined, a store with 0 < req_be < all-ones SHALL perform read-modify-write via IDLE->RD->WR->IDLE.
- WR writes ram_data = merge(ram_q, wdata, be), taking bytes of wdata where be=1 and bytes of ram_q otherwise.
- WR asserts resp_valid.
REQ-017 Without MEM_CTRL_BYTE_STORE_EN, req_be SHALL be ignored for non-zero values and every store with req_be != 0 SHALL be a full-word write per REQ-007; no merge logic is present.

Structure
REQ-018 A shared package mem_ctrl_pkg SHALL hold:
- state encoding constants (IDLE=2'd0, RD=2'd1, WR=2'd2, RSP=2'd3);
- default DATA_WIDTH/ADDR_WIDTH constants.
REQ-019 Byte merging SHALL be one sub-module be_merge (purely combinational, parameterised by DATA_WIDTH), instantiated only under MEM_CTRL_BYTE_STORE_EN.

Verification
REQ-020 The bench SHALL instantiate mem_ctrl with the RAM block on the same clock and cover:
- Reset, then store addr 5 data 0xDEADBEEF be 0xF, then load addr 5 -> ram_we high exactly 1 cycle; resp_rdata 0xDEADBEEF 2 cycles after load acceptance.
- Store addr 5 data 0x11223344 be 0xF, then next-accepted load addr 5 -> 0x11223344 (no stale data).
- With macro: preload 0xAABBCCDD at addr 9, store 0x00000055 be 0x1, load addr 9 -> 0xAABBCC55; without macro the same sequence -> 0x00000055.
- Store be 0x0 to addr 3 holding 0x12345678 -> resp_valid pulses, ram_we never asserts, load addr 3 -> 0x12345678.
- reset_n low during RD of a partial store -> no ram_we, no resp_valid, req_ready=1 in the first cycle after release.
- req_valid held continuously with alternating loads/stores -> req_ready only in IDLE, one resp_valid per request, spacing per REQ-012.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the mem_ctrl single-port RAM request controller:
// FSM state encoding and default geometry.
package mem_ctrl_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

endpackage : mem_ctrl_pkg

// File: rtl/mem_ctrl_be_merge.sv
// be_merge: purely combinational byte merge. Each output byte comes from
// i_new where the matching byte enable is set and from i_old otherwise.
// Only instantiated when MEM_CTRL_BYTE_STORE_EN is defined.
module be_merge #(
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic [DATA_WIDTH-1:0] i_old,
    input  logic [DATA_WIDTH-1:0] i_new,
    input  logic [BE_WIDTH-1:0]   i_be,
    output logic [DATA_WIDTH-1:0] o_merged
);

    genvar gi;
    generate
        for (gi = 0; gi < BE_WIDTH; gi++) begin : g_byte
            assign o_merged[gi*8 +: 8] = i_be[gi] ? i_new[gi*8 +: 8] : i_old[gi*8 +: 8];
        end
    endgenerate

endmodule : be_merge

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialising CPU-to-RAM controller. One request at a time;
// loads take IDLE->RD->RSP, stores take IDLE->WR (one-cycle write + ack).
// Optional feature macro: MEM_CTRL_BYTE_STORE_EN -- partial stores become
// read-modify-write (IDLE->RD->WR) using be_merge. Without it any store with
// a non-zero byte enable is a full-word write.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BE_WIDTH-1:0]   req_be,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    state_t                r_state;
    state_t                w_state_next;

    // Request fields captured at acceptance
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BE_WIDTH-1:0]   r_be;

    // Last values driven to the RAM, presented while the owning state is inactive
    logic [ADDR_WIDTH-1:0] r_raddr_hold;
    logic [ADDR_WIDTH-1:0] r_waddr_hold;
    logic [DATA_WIDTH-1:0] r_wdata_hold;

    logic                  w_accept;
    logic                  w_be_any;
    logic [DATA_WIDTH-1:0] w_store_data;

    assign w_accept = req_valid && req_ready;
    assign w_be_any = |r_be;

`ifdef MEM_CTRL_BYTE_STORE_EN
    logic w_req_partial;

    // A partial store needs the old word first, so it detours through RD
    assign w_req_partial = (req_be != '0) && (req_be != '1);

    // In WR after RD, ram_q holds the old word; full stores pass wdata through
    be_merge #(
        .DATA_WIDTH (DATA_WIDTH),
        .BE_WIDTH   (BE_WIDTH)
    ) u_be_merge (
        .i_old    (ram_q),
        .i_new    (r_wdata),
        .i_be     (r_be),
        .o_merged (w_store_data)
    );
`else
    logic w_req_partial;

    assign w_req_partial = 1'b0;
    assign w_store_data  = r_wdata;
`endif

    // State register; reset drops any in-flight request immediately
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!req_we || w_req_partial) begin
                        w_state_next = RD;
                    end else begin
                        w_state_next = WR;
                    end
                end
            end
            RD:      w_state_next = r_we ? WR : RSP;
            WR:      w_state_next = IDLE;
            RSP:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output decode from state; RAM ports show hold values outside their state
    always_comb begin
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = '0;
        ram_we         = 1'b0;
        ram_read_addr  = r_raddr_hold;
        ram_write_addr = r_waddr_hold;
        ram_data       = r_wdata_hold;
        case (r_state)
            IDLE: req_ready = reset_n;
            RD:   ram_read_addr = r_addr;
            WR: begin
                ram_we         = w_be_any;
                ram_write_addr = r_addr;
                ram_data       = w_store_data;
                resp_valid     = 1'b1;
            end
            RSP: begin
                resp_valid = 1'b1;
                resp_rdata = ram_q;
            end
            default: ;
        endcase
    end

    // Capture the request on acceptance
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    // Remember what was last driven so the RAM ports hold between uses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_raddr_hold <= '0;
            r_waddr_hold <= '0;
            r_wdata_hold <= '0;
        end else begin
            if (r_state == RD) begin
                r_raddr_hold <= r_addr;
            end
            if (r_state == WR) begin
                r_waddr_hold <= r_addr;
                r_wdata_hold <= w_store_data;
            end
        end
    end

endmodule : mem_ctrl

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl with a behavioural RAM (registered read, old data on
// collision) on the same clock. Expected values that depend on
// MEM_CTRL_BYTE_STORE_EN are selected with the same macro.
module tb_mem_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [31:0] ram_data;
    logic [5:0]  ram_read_addr;
    logic [5:0]  ram_write_addr;
    logic        ram_we;
    logic [31:0] ram_q = '0;

    logic [31:0] mem [64];

    int pass_cnt = 0;
    int total_cnt = 0;
    int we_total = 0;
    int resp_total = 0;
    logic [5:0]  cap_waddr = '0;
    logic [31:0] cap_wdata = '0;

    always #5 clock = ~clock;

    mem_ctrl dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_be         (req_be),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .ram_data       (ram_data),
        .ram_read_addr  (ram_read_addr),
        .ram_write_addr (ram_write_addr),
        .ram_we         (ram_we),
        .ram_q          (ram_q)
    );

    always @(posedge clock) begin
        if (ram_we) mem[ram_write_addr] <= ram_data;
        ram_q <= mem[ram_read_addr];
    end

    always @(negedge clock) begin
        if (ram_we) begin
            we_total  <= we_total + 1;
            cap_waddr <= ram_write_addr;
            cap_wdata <= ram_data;
        end
        if (resp_valid) resp_total <= resp_total + 1;
    end

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_we;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [5:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [31:0] exp_rdata,
                                input int exp_lat, input int exp_we, input logic [31:0] exp_mem);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
        v.exp_rdata = exp_rdata; v.exp_lat = exp_lat; v.exp_we = exp_we; v.exp_mem = exp_mem;
        return v;
    endfunction

    // Issue one request, wait for acceptance and its response (bounded)
    task automatic do_txn(input vec_t v, input string tag);
        logic        acc;
        logic        got;
        int          lat;
        int          we0;
        int          rsp0;
        logic [31:0] rd;
        we0 = we_total; rsp0 = resp_total;
        req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be;
        req_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clock);
            acc = req_ready;
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        check({tag, " accepted"}, {31'd0, acc}, 32'd1);
        got = 1'b0; lat = 0; rd = '0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clock);
            if (resp_valid) begin
                got = 1'b1; lat = i; rd = resp_rdata;
            end
        end
        @(posedge clock);
        #1;
        check({tag, " latency"}, lat, v.exp_lat);
        check({tag, " rdata"}, rd, v.exp_rdata);
        check({tag, " ram_we cycles"}, we_total - we0, v.exp_we);
        check({tag, " resp pulses"}, resp_total - rsp0, 32'd1);
        if (v.exp_we == 1) begin
            check({tag, " write addr"}, {26'd0, cap_waddr}, {26'd0, v.addr});
            check({tag, " write data"}, cap_wdata, v.exp_mem);
        end
        $display("txn %s we=%0b addr=%0d wdata=%h be=%h -> rdata=%h lat=%0d",
                 tag, v.we, v.addr, v.wdata, v.be, rd, lat);
    endtask

    // Back-to-back stream bookkeeping
    logic        bb_we [5];
    logic [31:0] bb_wd [5];
    logic [31:0] bb_exp [5];
    int          acc_cyc [5];

    initial begin
`ifdef MEM_CTRL_BYTE_STORE_EN
        localparam logic [31:0] EXP9A = 32'hAABBCC55;
        localparam logic [31:0] EXP9B = 32'hAA345655;
        localparam int          LATP  = 2;
`else
        localparam logic [31:0] EXP9A = 32'h00000055;
        localparam logic [31:0] EXP9B = 32'h12345678;
        localparam int          LATP  = 1;
`endif
        vecs[0]  = mk(1, 6'd5,  32'hDEADBEEF, 4'hF, 32'h0,        1,    1, 32'hDEADBEEF);
        vecs[1]  = mk(0, 6'd5,  32'h0,        4'h0, 32'hDEADBEEF, 2,    0, 32'h0);
        vecs[2]  = mk(1, 6'd5,  32'h11223344, 4'hF, 32'h0,        1,    1, 32'h11223344);
        vecs[3]  = mk(0, 6'd5,  32'h0,        4'h0, 32'h11223344, 2,    0, 32'h0);
        vecs[4]  = mk(1, 6'd9,  32'hAABBCCDD, 4'hF, 32'h0,        1,    1, 32'hAABBCCDD);
        vecs[5]  = mk(1, 6'd9,  32'h00000055, 4'h1, 32'h0,        LATP, 1, EXP9A);
        vecs[6]  = mk(0, 6'd9,  32'h0,        4'h0, EXP9A,        2,    0, 32'h0);
        vecs[7]  = mk(1, 6'd9,  32'h12345678, 4'h6, 32'h0,        LATP, 1, EXP9B);
        vecs[8]  = mk(0, 6'd9,  32'h0,        4'h0, EXP9B,        2,    0, 32'h0);
        vecs[9]  = mk(1, 6'd3,  32'h12345678, 4'hF, 32'h0,        1,    1, 32'h12345678);
        vecs[10] = mk(1, 6'd3,  32'hFFFFFFFF, 4'h0, 32'h0,        1,    0, 32'h0);
        vecs[11] = mk(0, 6'd3,  32'h0,        4'h0, 32'h12345678, 2,    0, 32'h0);
        vecs[12] = mk(1, 6'd0,  32'hCAFEF00D, 4'hF, 32'h0,        1,    1, 32'hCAFEF00D);
        vecs[13] = mk(0, 6'd0,  32'h0,        4'h0, 32'hCAFEF00D, 2,    0, 32'h0);
        vecs[14] = mk(1, 6'd63, 32'h0BADC0DE, 4'hF, 32'h0,        1,    1, 32'h0BADC0DE);
        vecs[15] = mk(0, 6'd63, 32'h0,        4'h0, 32'h0BADC0DE, 2,    0, 32'h0);

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst req_ready", {31'd0, req_ready}, 32'd0);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst ram_we", {31'd0, ram_we}, 32'd0);
        check("rst ram_data", ram_data, 32'd0);
        check("rst ram_read_addr", {26'd0, ram_read_addr}, 32'd0);
        check("rst ram_write_addr", {26'd0, ram_write_addr}, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        #2 reset_n = 1'b1;
        @(negedge clock);
        check("release req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clock);
        #1;

        // Table-driven transactions
        for (int i = 0; i < 16; i++) begin
            do_txn(vecs[i], $sformatf("v%0d", i));
        end

        // Hold behaviour of RAM-side ports between uses
        check("hold read_addr", {26'd0, ram_read_addr}, 32'd63);
        check("hold write_addr", {26'd0, ram_write_addr}, 32'd63);
        check("hold ram_data", ram_data, 32'h0BADC0DE);
        do_txn(mk(1, 6'd3, 32'h33333333, 4'hF, 32'h0, 1, 1, 32'h33333333), "s3");
        check("hold read_addr after store", {26'd0, ram_read_addr}, 32'd63);
        check("write_addr after store", {26'd3, ram_write_addr} & 32'h3F, 32'd3);

        // Reset asserted one cycle into a partial store to addr 9
        begin
            int we0;
            int rsp0;
            logic rdy;
            we0 = we_total; rsp0 = resp_total;
            req_we = 1'b1; req_addr = 6'd9; req_wdata = 32'h0000EE00; req_be = 4'h2;
            req_valid = 1'b1;
            @(negedge clock);
            rdy = req_ready;
            @(posedge clock);
            #1;
            req_valid = 1'b0;
            reset_n = 1'b0;
            #1;
            check("midrst accepted", {31'd0, rdy}, 32'd1);
            check("midrst ram_we", {31'd0, ram_we}, 32'd0);
            check("midrst resp_valid", {31'd0, resp_valid}, 32'd0);
            check("midrst req_ready", {31'd0, req_ready}, 32'd0);
            repeat (2) @(negedge clock);
            check("midrst ram_we held", {31'd0, ram_we}, 32'd0);
            reset_n = 1'b1;
            @(negedge clock);
            check("midrst ready after release", {31'd0, req_ready}, 32'd1);
            @(posedge clock);
            #1;
            check("midrst no write", we_total - we0, 32'd0);
            check("midrst no resp", resp_total - rsp0, 32'd0);
            $display("txn midrst partial store addr 9 dropped by reset");
        end
        do_txn(mk(0, 6'd9, 32'h0, 4'h0, EXP9B, 2, 0, 32'h0), "after_rst_load9");

        // Continuous req_valid with alternating loads and stores to addr 5
        bb_we[0] = 0; bb_wd[0] = 32'h0;        bb_exp[0] = 32'h11223344;
        bb_we[1] = 1; bb_wd[1] = 32'h01010101; bb_exp[1] = 32'h0;
        bb_we[2] = 0; bb_wd[2] = 32'h0;        bb_exp[2] = 32'h01010101;
        bb_we[3] = 1; bb_wd[3] = 32'h02020202; bb_exp[3] = 32'h0;
        bb_we[4] = 0; bb_wd[4] = 32'h0;        bb_exp[4] = 32'h02020202;
        begin
            int idx;
            int rsp_idx;
            int cyc;
            int overlap;
            logic acc;
            idx = 0; rsp_idx = 0; cyc = 0; overlap = 0;
            for (int k = 0; k < 5; k++) acc_cyc[k] = 0;
            req_we = bb_we[0]; req_addr = 6'd5; req_wdata = bb_wd[0]; req_be = 4'hF;
            req_valid = 1'b1;
            while (rsp_idx < 5 && cyc < 40) begin
                @(negedge clock);
                cyc++;
                acc = req_ready && (idx < 5);
                if (req_ready && resp_valid) overlap++;
                if (resp_valid) begin
                    check($sformatf("bb rsp%0d rdata", rsp_idx), resp_rdata, bb_exp[rsp_idx]);
                    $display("txn bb%0d we=%0b addr=5 -> rdata=%h cycle=%0d",
                             rsp_idx, bb_we[rsp_idx], resp_rdata, cyc);
                    rsp_idx++;
                end
                if (acc) acc_cyc[idx] = cyc;
                @(posedge clock);
                #1;
                if (acc) begin
                    idx++;
                    if (idx < 5) begin
                        req_we = bb_we[idx]; req_wdata = bb_wd[idx];
                    end else begin
                        req_valid = 1'b0;
                    end
                end
            end
            req_valid = 1'b0;
            check("bb responses", rsp_idx, 32'd5);
            check("bb ready/resp overlap", overlap, 32'd0);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("bb spacing%0d", k), acc_cyc[k+1] - acc_cyc[k], bb_we[k] ? 32'd2 : 32'd3);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_mem_ctrl
